// File: rtl/ifu_fetch_if.sv
// Fetch-side bus bundle: redirect input, imem address/data and the decode handshake.
// The master modport is the fetch unit; the slave modport is the imem/decode side.
interface ifu_fetch_if;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] imem_addr_o;
    logic [31:0] instruct_i;
    logic        if_valid_o;
    logic        if_ready_i;
    logic [31:0] if_pc_o;
    logic [31:0] if_instr_o;
    logic [1:0]  if_fault_o;

    modport master (
        input  redirect_i, redirect_pc_i, instruct_i, if_ready_i,
        output imem_addr_o, if_valid_o, if_pc_o, if_instr_o, if_fault_o
    );

    modport slave (
        output redirect_i, redirect_pc_i, instruct_i, if_ready_i,
        input  imem_addr_o, if_valid_o, if_pc_o, if_instr_o, if_fault_o
    );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: PC register, combinational imem address, 2-entry fetch queue to decode,
// redirect flush and halt-on-fault for misaligned / out-of-range fetch addresses.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 2048,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input logic         clk_i,
    input logic         rst_i,
    ifu_fetch_if.master bus
);

    localparam logic [32:0] FETCH_LIMIT = 33'(IMEM_WORDS) * 33'd4;

    localparam logic [1:0] FAULT_NONE  = 2'b00;
    localparam logic [1:0] FAULT_ALIGN = 2'b01;
    localparam logic [1:0] FAULT_RANGE = 2'b10;

    // Misalignment is reported ahead of range so a bad low-bit target is never masked.
    function automatic logic [1:0] classify_pc(input logic [31:0] pc);
        if (pc[1:0] != 2'b00)
            return FAULT_ALIGN;
        else if ({1'b0, pc} >= FETCH_LIMIT)
            return FAULT_RANGE;
        else
            return FAULT_NONE;
    endfunction

    logic [31:0] pc_q;
    logic [1:0]  count_q;
    logic        halted_q;

    logic [31:0] q_pc    [2];
    logic [31:0] q_instr [2];
    logic [1:0]  q_fault [2];

    logic [1:0]  pc_fault;
    logic        push;
    logic        pop;
    logic        wr_idx;
    logic [1:0]  count_nxt;
    logic [31:0] push_instr;

    assign pc_fault   = classify_pc(pc_q);
    assign push       = !halted_q && (count_q < 2'd2) && !bus.redirect_i;
    assign pop        = bus.if_valid_o && bus.if_ready_i;
    assign push_instr = (pc_fault == FAULT_NONE) ? bus.instruct_i : NOP_INSTR;
    assign count_nxt  = count_q + {1'b0, push} - {1'b0, pop};

    // Queue is a 2-deep shift register with the head in slot 0; a simultaneous pop moves the tail down.
    always_comb begin
        wr_idx = count_q[0];
        if (pop)
            wr_idx = (count_q == 2'd2);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q     <= RESET_PC;
            count_q  <= 2'd0;
            halted_q <= 1'b0;
        end else if (bus.redirect_i) begin
            pc_q     <= bus.redirect_pc_i;
            count_q  <= 2'd0;
            halted_q <= 1'b0;
        end else begin
            count_q <= count_nxt;
            if (push) begin
                if (pc_fault == FAULT_NONE)
                    pc_q <= pc_q + 32'd4;
                else
                    halted_q <= 1'b1;
            end
        end
    end

    // Queue payload carries no reset; count_q alone decides what is live.
    always_ff @(posedge clk_i) begin
        if (pop) begin
            q_pc[0]    <= q_pc[1];
            q_instr[0] <= q_instr[1];
            q_fault[0] <= q_fault[1];
        end
        if (push) begin
            q_pc[wr_idx]    <= pc_q;
            q_instr[wr_idx] <= push_instr;
            q_fault[wr_idx] <= pc_fault;
        end
    end

    assign bus.imem_addr_o = pc_q;
    assign bus.if_valid_o  = (count_q != 2'd0);
    assign bus.if_pc_o     = bus.if_valid_o ? q_pc[0]    : 32'd0;
    assign bus.if_instr_o  = bus.if_valid_o ? q_instr[0] : NOP_INSTR;
    assign bus.if_fault_o  = bus.if_valid_o ? q_fault[0] : FAULT_NONE;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch; the imem model returns word index = address/4.
module tb_ifu_fetch;

    logic clk_i;
    logic rst_i;
    int   total;
    int   bad;

    localparam logic [31:0] NOP = 32'h0000_0013;

    ifu_fetch_if bus();

    ifu_fetch #(
        .RESET_PC  (32'h0000_0000),
        .IMEM_WORDS(2048),
        .NOP_INSTR (NOP)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus  (bus.master)
    );

    assign bus.instruct_i = {2'b00, bus.imem_addr_o[31:2]};

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_idle(input string tag, input logic [31:0] addr);
        chk({tag, ".valid"}, {31'd0, bus.if_valid_o}, 32'd0);
        chk({tag, ".pc"},    bus.if_pc_o, 32'd0);
        chk({tag, ".instr"}, bus.if_instr_o, NOP);
        chk({tag, ".fault"}, {30'd0, bus.if_fault_o}, 32'd0);
        chk({tag, ".addr"},  bus.imem_addr_o, addr);
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                            input logic [1:0] fault, input logic [31:0] addr);
        chk({tag, ".valid"}, {31'd0, bus.if_valid_o}, 32'd1);
        chk({tag, ".pc"},    bus.if_pc_o, pc);
        chk({tag, ".instr"}, bus.if_instr_o, instr);
        chk({tag, ".fault"}, {30'd0, bus.if_fault_o}, {30'd0, fault});
        chk({tag, ".addr"},  bus.imem_addr_o, addr);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_i = 1'b1;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 32'd0;
        bus.if_ready_i    = 1'b1;

        // Reset state and streaming at one instruction per cycle
        step();
        step();
        chk_idle("rst", 32'h0);
        rst_i = 1'b0;
        step();
        chk_head("stream0", 32'h0, 32'd0, 2'b00, 32'h4);
        step();
        chk_head("stream1", 32'h4, 32'd1, 2'b00, 32'h8);
        step();
        chk_head("stream2", 32'h8, 32'd2, 2'b00, 32'hC);

        // Backpressure: queue fills to 2 and the head holds
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        bus.if_ready_i = 1'b0;
        step();
        chk_head("bp0", 32'h0, 32'd0, 2'b00, 32'h4);
        for (int i = 0; i < 4; i++) begin
            step();
            chk_head("bp_hold", 32'h0, 32'd0, 2'b00, 32'h8);
        end
        bus.if_ready_i = 1'b1;
        step();
        chk_head("bp_drain1", 32'h4, 32'd1, 2'b00, 32'h8);
        step();
        chk_head("bp_drain2", 32'h8, 32'd2, 2'b00, 32'hC);

        // Redirect with a full queue and a same-cycle pop
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        bus.if_ready_i = 1'b0;
        step();
        step();
        chk_head("full", 32'h0, 32'd0, 2'b00, 32'h8);
        bus.if_ready_i    = 1'b1;
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h100;
        step();
        bus.redirect_i = 1'b0;
        chk_idle("redir_flush", 32'h100);
        step();
        chk_head("redir_new0", 32'h100, 32'h40, 2'b00, 32'h104);
        step();
        chk_head("redir_new1", 32'h104, 32'h41, 2'b00, 32'h108);

        // Misaligned target: one fault entry then halted
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h102;
        step();
        bus.redirect_i = 1'b0;
        chk_idle("mis_flush", 32'h102);
        step();
        chk_head("mis_fault", 32'h102, NOP, 2'b01, 32'h102);
        step();
        chk_idle("mis_halt0", 32'h102);
        step();
        chk_idle("mis_halt1", 32'h102);
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h200;
        step();
        bus.redirect_i = 1'b0;
        chk_idle("resume_flush", 32'h200);
        step();
        chk_head("resume0", 32'h200, 32'h80, 2'b00, 32'h204);

        // Run off the end of imem
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h1FF8;
        step();
        bus.redirect_i = 1'b0;
        chk_idle("end_flush", 32'h1FF8);
        step();
        chk_head("end0", 32'h1FF8, 32'h7FE, 2'b00, 32'h1FFC);
        step();
        chk_head("end1", 32'h1FFC, 32'h7FF, 2'b00, 32'h2000);
        step();
        chk_head("end_fault", 32'h2000, NOP, 2'b10, 32'h2000);
        step();
        chk_idle("end_halt0", 32'h2000);
        step();
        chk_idle("end_halt1", 32'h2000);

        // Reset beats a simultaneous redirect while the queue is full
        bus.if_ready_i    = 1'b0;
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h300;
        step();
        bus.redirect_i = 1'b0;
        step();
        step();
        chk_head("pre_rst_full", 32'h300, 32'hC0, 2'b00, 32'h308);
        rst_i             = 1'b1;
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h40;
        step();
        rst_i          = 1'b0;
        bus.redirect_i = 1'b0;
        bus.if_ready_i = 1'b1;
        chk_idle("rst_redir", 32'h0);
        step();
        chk_head("rst_redir0", 32'h0, 32'd0, 2'b00, 32'h4);
        step();
        chk_head("rst_redir1", 32'h4, 32'd1, 2'b00, 32'h8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
